wired_inst_pkg_queue: RTL
=========================

Name: wired_inst_pkg_queue

Overview:
- Frontend-side producer of the 2-wide instruction package stream consumed by the backend rename stage (`pkg_valid`/`pkg_ready`/`pkg_mask`/`pkg`).
- Buffers fetched/decoded instruction slots in a circular FIFO and compacts holes so lane 0 is always the oldest.
- Drops wrong-path slots by branch-thread id (tid) and flushes on a backend redirect.

Parameters:
- DEPTH, 8, slot entries; power of two, at least 4.
- PKG_WIDTH, 128, bits per instruction slot; the payload is opaque to this block.
- TID_WIDTH, 1, width of the redirect thread id.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- f_valid_i  in  1  fetch group valid
- f_ready_o  out  1  queue can accept a fetch group
- f_mask_i  in  2  per-lane slot valid; lane 0 is older than lane 1
- f_tid_i  in  TID_WIDTH  tid of the fetch group
- f_pkg_i  in  2*PKG_WIDTH  slot payloads, lane 0 in the low bits
- pkg_valid_o  out  1  package valid toward the backend
- pkg_ready_i  in  1  backend accepts the package
- pkg_mask_o  out  2  output lane valid; only 2'b01 or 2'b11
- pkg_o  out  2*PKG_WIDTH  output payloads, lane 0 is the oldest
- redirect_i  in  1  backend redirect / flush (bpu_correct redirect)
- redirect_tid_i  in  TID_WIDTH  new tid
- count_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- **Reset:**
  - head, tail, count and epoch all reset to 0.
  - Outputs at reset: f_ready_o=1, pkg_valid_o=0, pkg_mask_o=0, count_o=0.
  - Payload RAM is not reset.
- **Enqueue acceptance:**
  - f_ready_o = (DEPTH - count >= 2). It is derived from registered count only, never from pkg_ready_i.
  - A fetch group is accepted when f_valid_i & f_ready_o.
  - The group is written only if f_tid_i == epoch and redirect_i == 0. Otherwise it is consumed and discarded.
- **Enqueue compaction:**
  - Mask 11: lane 0 goes to tail, lane 1 to tail+1, tail += 2.
  - Mask 01: lane 0 goes to tail, tail += 1.
  - Mask 10: lane 1 goes to tail, tail += 1.
  - Mask 00: no write.
- **Output:**
  - pkg_valid_o = (count != 0).
  - pkg_mask_o = 2'b11 if count >= 2, 2'b01 if count == 1, 2'b00 if empty.
  - pkg_o lane 0 = mem[head]; lane 1 = mem[head+1]. Lane 1 is don't-care when its mask bit is 0.
  - Output is combinational from registered state.
- **Dequeue:**
  - On pkg_valid_o & pkg_ready_i, head += popcount(pkg_mask_o).
  - The backend consumes every masked lane in one handshake.
- **Count update:** count_next = count + enq_n - deq_n. Simultaneous enqueue and dequeue are legal at any occupancy, including full-2 and 1.
- **Pointers:** head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH. The +1 address also wraps: at head = DEPTH-1, lane 1 reads mem[0].
- **Redirect (highest priority):**
  - Same cycle: head <= 0, tail <= 0, count <= 0, epoch <= redirect_tid_i.
  - Any simultaneous enqueue is discarded.
  - A simultaneous dequeue handshake still completes on the bus, but has no state effect beyond the flush.
  - Next cycle: pkg_valid_o=0.
- **Epoch:** holds its value between redirects. Later fetch groups carrying the old tid are dropped until the frontend catches up.
- **Reset mid-operation:** asynchronous return to the reset state; any in-flight handshake is void.
- **Protocol stability:**
  - While pkg_valid_o=1 and pkg_ready_i=0, pkg_o and lane 0 stay stable.
  - pkg_mask_o may only grow, from 01 to 11, when a new slot arrives.

Optional Feature:
- **Macro:** WIRED_IBUF_BYPASS_EN.
- **With the macro defined:**
  - Applies when count == 0, redirect_i == 0, f_valid_i == 1, f_tid_i == epoch and f_mask_i != 0.
  - pkg_valid_o=1 in the same cycle.
  - pkg_o and pkg_mask_o carry the compacted input: mask 10 is shifted to lane 0 and output as mask 01.
  - If pkg_ready_i=1, nothing is written and count stays 0. Otherwise the slots are written as in a normal enqueue.
  - Zero-cycle latency; count_o is unaffected by bypassed slots.
- **Without the macro:** minimum enqueue-to-output latency is 1 cycle.

Test Plan:
- Reset, then push mask 11 with tid 0 and payloads A,B, pkg_ready_i=1 → next cycle pkg_valid_o=1, mask 11, lanes A,B; the cycle after, count_o=0.
- Push mask 10 (payload C in lane 1), then mask 01 (D) → output lanes C,D, mask 11; count_o goes 1 then 2.
- Hold pkg_ready_i=0 and push 2 slots per cycle with DEPTH=8 → f_ready_o drops after count_o=8. It stays low at count 7 only if reached, and re-asserts once count ≤6 after dequeues.
- Fill to count 3 with head=6, dequeue with ready → lanes mem[6],mem[7], then mem[0] with mask 01; verifies wrap-around.
- Assert redirect_i with tid 1 while enqueuing tid 0 → count_o=0 next cycle. Further tid-0 groups are accepted but dropped; tid-1 groups appear at the output.
- With WIRED_IBUF_BYPASS_EN, empty queue, push mask 01 (E) with ready=1 → same cycle pkg_valid_o=1, lane 0 = E, count_o stays 0.

Source files
------------

// File: rtl/wired_inst_pkg_queue.sv
// wired_inst_pkg_queue: 2-wide instruction package FIFO with hole compaction, tid drop and redirect flush.
// Optional same-cycle empty-queue bypass enabled by defining WIRED_IBUF_BYPASS_EN.
`default_nettype none

module wired_inst_pkg_queue #(
  parameter int DEPTH     = 8,
  parameter int PKG_WIDTH = 128,
  parameter int TID_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     f_valid_i,
  output logic                     f_ready_o,
  input  logic [1:0]               f_mask_i,
  input  logic [TID_WIDTH-1:0]     f_tid_i,
  input  logic [2*PKG_WIDTH-1:0]   f_pkg_i,
  output logic                     pkg_valid_o,
  input  logic                     pkg_ready_i,
  output logic [1:0]               pkg_mask_o,
  output logic [2*PKG_WIDTH-1:0]   pkg_o,
  input  logic                     redirect_i,
  input  logic [TID_WIDTH-1:0]     redirect_tid_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_READY_MAX = CW'(DEPTH - 2);
  localparam logic [CW-1:0] C_TWO       = CW'(2);

  logic [PKG_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_head;
  logic [AW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic [TID_WIDTH-1:0] r_epoch;

  logic [PKG_WIDTH-1:0] w_lane0;
  logic [PKG_WIDTH-1:0] w_lane1;
  logic [PKG_WIDTH-1:0] w_c0;
  logic [AW-1:0]        w_head1;
  logic [AW-1:0]        w_tail1;
  logic                 w_fire;
  logic                 w_tid_ok;
  logic                 w_byp;
  logic                 w_wr;
  logic                 w_deq;
  logic [1:0]           w_q_mask;
  logic [1:0]           w_in_n;
  logic [1:0]           w_q_n;
  logic [1:0]           w_enq_n;
  logic [1:0]           w_deq_n;

  assign w_lane0  = f_pkg_i[PKG_WIDTH-1:0];
  assign w_lane1  = f_pkg_i[2*PKG_WIDTH-1:PKG_WIDTH];
  // A lone lane-1 slot is shifted down so the oldest valid slot always lands at tail.
  assign w_c0     = f_mask_i[0] ? w_lane0 : w_lane1;
  assign w_head1  = r_head + AW'(1);
  assign w_tail1  = r_tail + AW'(1);

  assign f_ready_o = (r_count <= C_READY_MAX);
  assign count_o   = r_count;
  assign w_fire    = f_valid_i & f_ready_o;
  assign w_tid_ok  = (f_tid_i == r_epoch);

`ifdef WIRED_IBUF_BYPASS_EN
  assign w_byp = (r_count == '0) & ~redirect_i & f_valid_i & w_tid_ok & (f_mask_i != 2'b00);
`else
  assign w_byp = 1'b0;
`endif

  assign w_q_mask = (r_count >= C_TWO)  ? 2'b11 :
                    (r_count != '0)     ? 2'b01 : 2'b00;

  always_comb begin
    pkg_valid_o = w_byp | (r_count != '0);
    pkg_mask_o  = w_q_mask;
    pkg_o       = {r_mem[w_head1], r_mem[r_head]};
    if (w_byp) begin
      pkg_mask_o = (f_mask_i == 2'b11) ? 2'b11 : 2'b01;
      pkg_o      = {w_lane1, w_c0};
    end
  end

  // A bypassed group that the backend takes this cycle never touches the RAM.
  assign w_wr    = w_fire & w_tid_ok & ~redirect_i & ~(w_byp & pkg_ready_i);
  assign w_deq   = pkg_valid_o & pkg_ready_i & ~w_byp;
  assign w_in_n  = {1'b0, f_mask_i[1]} + {1'b0, f_mask_i[0]};
  assign w_q_n   = {1'b0, w_q_mask[1]} + {1'b0, w_q_mask[0]};
  assign w_enq_n = w_wr  ? w_in_n : 2'b00;
  assign w_deq_n = w_deq ? w_q_n  : 2'b00;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      if (f_mask_i != 2'b00) r_mem[r_tail]  <= w_c0;
      if (f_mask_i == 2'b11) r_mem[w_tail1] <= w_lane1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_epoch <= '0;
    end else if (redirect_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_epoch <= redirect_tid_i;
    end else begin
      r_head  <= r_head + AW'(w_deq_n);
      r_tail  <= r_tail + AW'(w_enq_n);
      r_count <= r_count + CW'(w_enq_n) - CW'(w_deq_n);
    end
  end

endmodule

`default_nettype wire
